ex_hazard_ctrl: RTL and testbench

Hazard and sequencing controller for the execute stage of the 5-stage MIPS pipeline. Generates operand-forwarding selects for the execute operands a/b, load-use stalls, multi-cycle stalls for mult, and pipeline flushes for taken beq/j/call. Sits beside decode/execute and drives the stall/flush inputs of the IF/ID and ID/EX pipeline registers.

---
 rtl/ex_hazard_if.sv | 41 ++++
 rtl/ex_hazard_ctrl.sv | 116 +++++++++++
 tb/tb_ex_hazard_ctrl.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ex_hazard_if.sv
// Signal bundle between the execute-stage pipeline and ex_hazard_ctrl.
// There is no valid/ready handshake here: every signal is level-sampled each cycle.
interface ex_hazard_if #(
    parameter int CNT_W = 16
);
    logic [5:0]       id_opcode;
    logic [4:0]       id_src;
    logic [4:0]       id_target;
    logic [5:0]       ex_opcode;
    logic [4:0]       ex_src;
    logic [4:0]       ex_target;
    logic [4:0]       ex_wreg;
    logic             ex_we;
    logic [4:0]       mem_wreg;
    logic             mem_we;
    logic [4:0]       wb_wreg;
    logic             wb_we;
    logic             br_taken;
    logic [1:0]       fwd_a;
    logic [1:0]       fwd_b;
    logic             stall;
    logic             flush_id;
    logic             flush_ex;
    logic             mult_busy;
    logic [CNT_W-1:0] stall_cnt;
    logic             dbg_state;

    modport master (
        output id_opcode, id_src, id_target, ex_opcode, ex_src, ex_target,
               ex_wreg, ex_we, mem_wreg, mem_we, wb_wreg, wb_we, br_taken,
        input  fwd_a, fwd_b, stall, flush_id, flush_ex, mult_busy, stall_cnt,
               dbg_state
    );

    modport slave (
        input  id_opcode, id_src, id_target, ex_opcode, ex_src, ex_target,
               ex_wreg, ex_we, mem_wreg, mem_we, wb_wreg, wb_we, br_taken,
        output fwd_a, fwd_b, stall, flush_id, flush_ex, mult_busy, stall_cnt,
               dbg_state
    );
endinterface

// File: rtl/ex_hazard_ctrl.sv
// Execute-stage hazard controller: operand forwarding, load-use and mult stalls,
// and IF/ID / ID/EX flushes for taken branches, jumps and calls.
module ex_hazard_ctrl #(
    parameter int MULT_LAT = 4,
    parameter int CNT_W    = 16
) (
    input logic        clk,
    input logic        reset,
    ex_hazard_if.slave bus
);
    localparam logic [5:0] OP_ADDU = 6'd1;
    localparam logic [5:0] OP_BEQ  = 6'd2;
    localparam logic [5:0] OP_LW   = 6'd3;
    localparam logic [5:0] OP_MULT = 6'd4;
    localparam logic [5:0] OP_ADDI = 6'd5;
    localparam logic [5:0] OP_J    = 6'd6;
    localparam logic [5:0] OP_CALL = 6'd8;

    localparam int              MC_W        = (MULT_LAT > 2) ? $clog2(MULT_LAT - 1) : 1;
    localparam int              MC_INIT     = (MULT_LAT > 1) ? MULT_LAT - 2 : 0;
    localparam logic [MC_W-1:0] MC_LOAD     = MC_W'(MC_INIT);
    localparam bit              MULT_STALLS = (MULT_LAT > 1);

    typedef enum logic {IDLE = 1'b0, MBUSY = 1'b1} state_t;

    state_t           state, state_nxt;
    logic [MC_W-1:0]  mcnt, mcnt_nxt;
    logic [CNT_W-1:0] stall_cnt;

    logic reads_src, reads_tgt, redirect, load_use, mult_entry;
    logic stall_c, flush_id_c, flush_ex_c, busy_c, stall_o;

    function automatic logic [1:0] fwd_sel(input logic [4:0] r,
                                           input logic       m_we, input logic [4:0] m_reg,
                                           input logic       w_we, input logic [4:0] w_reg);
        if (m_we && m_reg != 5'd0 && m_reg == r)      return 2'b01;
        else if (w_we && w_reg != 5'd0 && w_reg == r) return 2'b10;
        else                                          return 2'b00;
    endfunction

    always_comb begin
        reads_src = 1'b0;
        reads_tgt = 1'b0;
        case (bus.id_opcode)
            OP_ADDU, OP_BEQ, OP_MULT: begin
                reads_src = 1'b1;
                reads_tgt = 1'b1;
            end
            OP_LW, OP_ADDI: reads_src = 1'b1;
            default: ;
        endcase
    end

    assign redirect   = bus.br_taken || (bus.ex_opcode == OP_J) || (bus.ex_opcode == OP_CALL);
    assign load_use   = (bus.ex_opcode == OP_LW) && (bus.ex_wreg != 5'd0) &&
                        ((reads_src && bus.id_src == bus.ex_wreg) ||
                         (reads_tgt && bus.id_target == bus.ex_wreg));
    assign mult_entry = MULT_STALLS && (bus.ex_opcode == OP_MULT) && !redirect;

    // The mult stays in EX while busy, so redirect/load-use are not evaluated in MBUSY.
    always_comb begin
        state_nxt  = state;
        mcnt_nxt   = mcnt;
        stall_c    = 1'b0;
        flush_id_c = 1'b0;
        flush_ex_c = 1'b0;
        busy_c     = 1'b0;
        case (state)
            IDLE: begin
                if (mult_entry) begin
                    stall_c   = 1'b1;
                    state_nxt = MBUSY;
                    mcnt_nxt  = MC_LOAD;
                end else if (redirect) begin
                    flush_id_c = 1'b1;
                    flush_ex_c = 1'b1;
                end else if (load_use) begin
                    stall_c    = 1'b1;
                    flush_ex_c = 1'b1;
                end
            end
            MBUSY: begin
                busy_c = 1'b1;
                if (mcnt == '0) begin
                    state_nxt = IDLE;
                end else begin
                    stall_c  = 1'b1;
                    mcnt_nxt = mcnt - MC_W'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            mcnt      <= '0;
            stall_cnt <= '0;
        end else begin
            state <= state_nxt;
            mcnt  <= mcnt_nxt;
            if (stall_o && (stall_cnt != {CNT_W{1'b1}}))
                stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

    assign stall_o       = reset & stall_c;
    assign bus.stall     = stall_o;
    assign bus.flush_id  = reset & flush_id_c;
    assign bus.flush_ex  = reset & flush_ex_c;
    assign bus.mult_busy = reset & busy_c;
    assign bus.fwd_a     = reset ? fwd_sel(bus.ex_src, bus.mem_we, bus.mem_wreg, bus.wb_we, bus.wb_wreg) : 2'b00;
    assign bus.fwd_b     = reset ? fwd_sel(bus.ex_target, bus.mem_we, bus.mem_wreg, bus.wb_we, bus.wb_wreg) : 2'b00;
    assign bus.stall_cnt = stall_cnt;
    assign bus.dbg_state = (state == MBUSY);
endmodule

// File: tb/tb_ex_hazard_ctrl.sv
// Bench for ex_hazard_ctrl: three instances (MULT_LAT 4/1, CNT_W 16/4) driven in lockstep
// and compared every cycle against a pipeline-level reference model.
module tb_ex_hazard_ctrl;
    localparam int W = 40;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic [5:0] id_opcode, ex_opcode;
    logic [4:0] id_src, id_target, ex_src, ex_target, ex_wreg, mem_wreg, wb_wreg;
    logic       ex_we, mem_we, wb_we, br_taken;

    ex_hazard_if #(.CNT_W(16)) bus0 ();
    ex_hazard_if #(.CNT_W(16)) bus1 ();
    ex_hazard_if #(.CNT_W(4))  bus2 ();

    assign bus0.id_opcode = id_opcode; assign bus1.id_opcode = id_opcode; assign bus2.id_opcode = id_opcode;
    assign bus0.id_src    = id_src;    assign bus1.id_src    = id_src;    assign bus2.id_src    = id_src;
    assign bus0.id_target = id_target; assign bus1.id_target = id_target; assign bus2.id_target = id_target;
    assign bus0.ex_opcode = ex_opcode; assign bus1.ex_opcode = ex_opcode; assign bus2.ex_opcode = ex_opcode;
    assign bus0.ex_src    = ex_src;    assign bus1.ex_src    = ex_src;    assign bus2.ex_src    = ex_src;
    assign bus0.ex_target = ex_target; assign bus1.ex_target = ex_target; assign bus2.ex_target = ex_target;
    assign bus0.ex_wreg   = ex_wreg;   assign bus1.ex_wreg   = ex_wreg;   assign bus2.ex_wreg   = ex_wreg;
    assign bus0.ex_we     = ex_we;     assign bus1.ex_we     = ex_we;     assign bus2.ex_we     = ex_we;
    assign bus0.mem_wreg  = mem_wreg;  assign bus1.mem_wreg  = mem_wreg;  assign bus2.mem_wreg  = mem_wreg;
    assign bus0.mem_we    = mem_we;    assign bus1.mem_we    = mem_we;    assign bus2.mem_we    = mem_we;
    assign bus0.wb_wreg   = wb_wreg;   assign bus1.wb_wreg   = wb_wreg;   assign bus2.wb_wreg   = wb_wreg;
    assign bus0.wb_we     = wb_we;     assign bus1.wb_we     = wb_we;     assign bus2.wb_we     = wb_we;
    assign bus0.br_taken  = br_taken;  assign bus1.br_taken  = br_taken;  assign bus2.br_taken  = br_taken;

    ex_hazard_ctrl #(.MULT_LAT(4), .CNT_W(16)) u0 (.clk(clk), .reset(reset), .bus(bus0));
    ex_hazard_ctrl #(.MULT_LAT(1), .CNT_W(16)) u1 (.clk(clk), .reset(reset), .bus(bus1));
    ex_hazard_ctrl #(.MULT_LAT(4), .CNT_W(4))  u2 (.clk(clk), .reset(reset), .bus(bus2));

    // Reference model: age = cycles a mult has already spent in EX (0 = none held).
    int lat_of[3] = '{4, 1, 4};
    int cmax[3]   = '{65535, 65535, 15};
    int age[3];
    int scnt[3];
    bit st_e[3];
    bit en_e[3];
    logic [W-1:0] exp_q[$];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [1:0] ref_fwd(input logic [4:0] r);
        // Producers listed youngest first; the youngest matching writer supplies the value.
        logic [4:0] preg[2];
        logic       pwe[2];
        preg = '{mem_wreg, wb_wreg};
        pwe  = '{mem_we, wb_we};
        for (int k = 0; k < 2; k++)
            if (pwe[k] && preg[k] != 5'd0 && preg[k] == r) return (k == 0) ? 2'b01 : 2'b10;
        return 2'b00;
    endfunction

    function automatic bit uses_reg(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                                    input logic [4:0] r);
        int op_i;
        op_i = int'(op);
        if (op_i == 1 || op_i == 2 || op_i == 4) return (rs == r) || (rt == r);
        if (op_i == 3 || op_i == 5)              return (rs == r);
        return 1'b0;
    endfunction

    task automatic model_expect(input int i, output logic [W-1:0] e);
        logic [1:0] fa, fb;
        logic st, fi, fe, bz;
        bit redirect, lu;
        fa = 2'b00; fb = 2'b00; st = 1'b0; fi = 1'b0; fe = 1'b0; bz = 1'b0;
        en_e[i] = 1'b0;
        if (reset) begin
            fa = ref_fwd(ex_src);
            fb = ref_fwd(ex_target);
            redirect = br_taken || ex_opcode == 6'd6 || ex_opcode == 6'd8;
            lu = ex_opcode == 6'd3 && ex_wreg != 5'd0 && uses_reg(id_opcode, id_src, id_target, ex_wreg);
            if (age[i] > 0) begin
                bz = 1'b1;
                st = (age[i] < lat_of[i] - 1);
            end else if (ex_opcode == 6'd4 && lat_of[i] > 1 && !redirect) begin
                st = 1'b1;
                en_e[i] = 1'b1;
            end else if (redirect) begin
                fi = 1'b1;
                fe = 1'b1;
            end else if (lu) begin
                st = 1'b1;
                fe = 1'b1;
            end
        end
        st_e[i] = st;
        e = {fa, fb, st, fi, fe, bz, 32'(scnt[i])};
    endtask

    function automatic logic [W-1:0] observed(input int i);
        case (i)
            0: return {bus0.fwd_a, bus0.fwd_b, bus0.stall, bus0.flush_id, bus0.flush_ex, bus0.mult_busy, 32'(bus0.stall_cnt)};
            1: return {bus1.fwd_a, bus1.fwd_b, bus1.stall, bus1.flush_id, bus1.flush_ex, bus1.mult_busy, 32'(bus1.stall_cnt)};
            default: return {bus2.fwd_a, bus2.fwd_b, bus2.stall, bus2.flush_id, bus2.flush_ex, bus2.mult_busy, 32'(bus2.stall_cnt)};
        endcase
    endfunction

    // Called with clk low and inputs settled; returns at the following negedge.
    task automatic cycle();
        logic [W-1:0] e, a;
        #1;
        for (int i = 0; i < 3; i++) begin
            if (!reset) begin
                age[i]  = 0;
                scnt[i] = 0;
            end
            model_expect(i, e);
            exp_q.push_back(e);
        end
        for (int i = 0; i < 3; i++) begin
            e = exp_q.pop_front();
            a = observed(i);
            check($sformatf("u%0d.fwd_a", i),     32'(a[39:38]), 32'(e[39:38]));
            check($sformatf("u%0d.fwd_b", i),     32'(a[37:36]), 32'(e[37:36]));
            check($sformatf("u%0d.stall", i),     32'(a[35]),    32'(e[35]));
            check($sformatf("u%0d.flush_id", i),  32'(a[34]),    32'(e[34]));
            check($sformatf("u%0d.flush_ex", i),  32'(a[33]),    32'(e[33]));
            check($sformatf("u%0d.mult_busy", i), 32'(a[32]),    32'(e[32]));
            check($sformatf("u%0d.stall_cnt", i), a[31:0],       e[31:0]);
        end
        @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            if (!reset) begin
                age[i]  = 0;
                scnt[i] = 0;
            end else begin
                if (st_e[i] && scnt[i] < cmax[i]) scnt[i]++;
                if (age[i] > 0)   age[i] = (age[i] >= lat_of[i] - 1) ? 0 : age[i] + 1;
                else if (en_e[i]) age[i] = 1;
            end
        end
        @(negedge clk);
    endtask

    task automatic set_quiet();
        id_opcode = 6'd7; id_src = 5'd0; id_target = 5'd0;
        ex_opcode = 6'd7; ex_src = 5'd0; ex_target = 5'd0; ex_wreg = 5'd0; ex_we = 1'b0;
        mem_wreg = 5'd0; mem_we = 1'b0; wb_wreg = 5'd0; wb_we = 1'b0; br_taken = 1'b0;
    endtask

    task automatic set_load_use();
        ex_opcode = 6'd3; ex_wreg = 5'd7; ex_we = 1'b1;
        id_opcode = 6'd1; id_src = 5'd1; id_target = 5'd7;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] c0;
        for (int i = 0; i < 3; i++) begin age[i] = 0; scnt[i] = 0; end
        set_quiet();
        #2 reset = 1'b0;
        @(negedge clk);

        // Reset holds every output low even with a load-use pattern present.
        set_load_use();
        #1;
        check("rst_stall", 32'(bus0.stall), 32'd0);
        check("rst_flush_ex", 32'(bus0.flush_ex), 32'd0);
        cycle();
        reset = 1'b1;
        set_quiet();
        cycle();

        // Forwarding: MEM beats WB, then WB alone, then r0 never forwarded.
        ex_opcode = 6'd1; ex_src = 5'd5; ex_target = 5'd5;
        mem_we = 1'b1; mem_wreg = 5'd5; wb_we = 1'b1; wb_wreg = 5'd5;
        #1;
        check("fwd_a_mem", 32'(bus0.fwd_a), 32'd1);
        check("fwd_b_mem", 32'(bus0.fwd_b), 32'd1);
        cycle();
        mem_we = 1'b0;
        #1;
        check("fwd_a_wb", 32'(bus0.fwd_a), 32'd2);
        cycle();
        mem_we = 1'b1; mem_wreg = 5'd0; wb_wreg = 5'd0; ex_src = 5'd0; ex_target = 5'd0;
        #1;
        check("fwd_a_r0", 32'(bus0.fwd_a), 32'd0);
        cycle();
        set_quiet();

        // Load-use bubble, then a non-dependent addi.
        set_load_use();
        #1;
        check("lu_stall", 32'(bus0.stall), 32'd1);
        check("lu_flush_ex", 32'(bus0.flush_ex), 32'd1);
        cycle();
        ex_opcode = 6'd7;
        cycle();
        set_load_use();
        id_opcode = 6'd5; id_src = 5'd3; id_target = 5'd7;
        #1;
        check("lu_addi_stall", 32'(bus0.stall), 32'd0);
        cycle();
        set_quiet();

        // Redirect wins over load-use; then j and call.
        set_load_use();
        br_taken = 1'b1;
        #1;
        check("br_flush_id", 32'(bus0.flush_id), 32'd1);
        check("br_stall", 32'(bus0.stall), 32'd0);
        cycle();
        br_taken = 1'b0; ex_opcode = 6'd6;
        cycle();
        ex_opcode = 6'd8;
        cycle();
        set_quiet();

        // Full mult: three stalled cycles on MULT_LAT=4, none on MULT_LAT=1.
        c0 = 32'(bus0.stall_cnt);
        ex_opcode = 6'd4; ex_src = 5'd2; ex_target = 5'd3;
        #1;
        check("mult1_nostall", 32'(bus1.stall), 32'd0);
        for (int k = 0; k < 4; k++) cycle();
        set_quiet();
        cycle();
        check("mult_cnt_delta", 32'(bus0.stall_cnt) - c0, 32'd3);

        // Reset during the second MBUSY cycle, then a full mult afterwards.
        ex_opcode = 6'd4;
        cycle();
        cycle();
        reset = 1'b0;
        #1;
        check("rst_mid_stall", 32'(bus0.stall), 32'd0);
        check("rst_mid_busy", 32'(bus0.mult_busy), 32'd0);
        check("rst_mid_cnt", 32'(bus0.stall_cnt), 32'd0);
        cycle();
        reset = 1'b1;
        ex_opcode = 6'd7;
        cycle();
        ex_opcode = 6'd4;
        for (int k = 0; k < 4; k++) cycle();
        set_quiet();
        cycle();
        check("mult_after_rst_cnt", 32'(bus0.stall_cnt), 32'd3);

        // Held load-use saturates the 4-bit counter.
        set_load_use();
        for (int k = 0; k < 20; k++) cycle();
        check("sat_cnt4", 32'(bus2.stall_cnt), 32'd15);
        set_quiet();
        cycle();

        for (int n = 0; n < 400; n++) begin
            reset     = ($urandom_range(0, 59) != 0);
            id_opcode = 6'($urandom_range(0, 9));
            id_src    = 5'($urandom_range(0, 7));
            id_target = 5'($urandom_range(0, 7));
            ex_opcode = 6'($urandom_range(0, 9));
            ex_src    = 5'($urandom_range(0, 7));
            ex_target = 5'($urandom_range(0, 7));
            ex_wreg   = 5'($urandom_range(0, 7));
            ex_we     = 1'($urandom_range(0, 1));
            mem_wreg  = 5'($urandom_range(0, 7));
            mem_we    = 1'($urandom_range(0, 1));
            wb_wreg   = 5'($urandom_range(0, 7));
            wb_we     = 1'($urandom_range(0, 1));
            br_taken  = ($urandom_range(0, 5) == 0) && (ex_opcode != 6'd4);
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
